// File: rtl/lsu_ctrl_if.sv
// Load/store bus bundle between the core memory stage, lsu_ctrl and the data memory.
// Core side:   req, we, funct3, addr, wdata in; busy, done, err, rdata out.
// Memory side: mem_addr, mem_wrt_data, mem_wrt out; mem_rd_data in (asynchronous read).
// slave  : the load/store controller.
// master : the environment around it (core stage plus data memory).
interface lsu_ctrl_if #(
  parameter int unsigned AW = 8
);
  logic          req;
  logic          we;
  logic [2:0]    funct3;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wrt_data;
  logic          mem_wrt;
  logic [31:0]   mem_rd_data;

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rd_data,
    output busy, done, err, rdata, mem_addr, mem_wrt_data, mem_wrt
  );

  modport master (
    output req, we, funct3, addr, wdata, mem_rd_data,
    input  busy, done, err, rdata, mem_addr, mem_wrt_data, mem_wrt
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store initiator for a word-organised data memory.
// Handles LB/LH/LW/LBU/LHU/SB/SH/SW with sign/zero extension, byte-lane
// selection and read-modify-write for sub-word stores; misaligned or illegal
// accesses are answered with err instead of touching memory.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - lsu_ctrl_if.slave: core request/response and data-memory signals
// Flow: IDLE -> (RD) -> (WR) -> RESP -> IDLE. Loads read in RD; SW writes
// straight from IDLE via WR; SB/SH read in RD, merge, then write in WR.
module lsu_ctrl #(
  parameter int unsigned AW = 8
) (
  input  logic      clk,
  input  logic      rst,
  lsu_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  // Latched byte address keeps only the bits that reach memory plus the lane bits.
  localparam int unsigned LAW = AW + 2;

  logic [1:0]     state;
  logic [1:0]     next_state;

  logic [LAW-1:0] lat_addr;
  logic           lat_we;
  logic [2:0]     lat_f3;
  logic [31:0]    lat_wdata;
  logic [31:0]    rbuf;

  logic           accept_c;
  logic           illegal_c;
  logic           misalign_c;
  logic           acc_err_c;
  logic [7:0]     byte_c;
  logic [15:0]    half_c;
  logic [31:0]    load_c;
  logic [31:0]    merge_c;

  // Upper address bits alias away; the memory is only 2^AW words deep.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:LAW];

  assign accept_c = (state == IDLE) && bus.req;

  // Error decode on the request as presented in IDLE.
  always_comb begin
    illegal_c  = bus.we ? (bus.funct3 > 3'd2)
                        : ((bus.funct3 == 3'd3) || (bus.funct3[2:1] == 2'b11));
    misalign_c = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    acc_err_c  = illegal_c || misalign_c;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (acc_err_c) begin
            next_state = RESP;
          end else if (bus.we && (bus.funct3 == 3'd2)) begin
            next_state = WR;
          end else begin
            next_state = RD;
          end
        end
      end
      RD:      next_state = lat_we ? WR : RESP;
      WR:      next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Lane extraction and extension of the word being read in RD.
  always_comb begin
    byte_c = bus.mem_rd_data[{lat_addr[1:0], 3'b000} +: 8];
    half_c = bus.mem_rd_data[{lat_addr[1], 4'b0000} +: 16];
    case (lat_f3)
      3'd0:    load_c = {{24{byte_c[7]}}, byte_c};
      3'd1:    load_c = {{16{half_c[15]}}, half_c};
      3'd4:    load_c = {24'd0, byte_c};
      3'd5:    load_c = {16'd0, half_c};
      default: load_c = bus.mem_rd_data;
    endcase
  end

  // Store word: full word for SW, otherwise rbuf with the addressed lane replaced.
  always_comb begin
    merge_c = rbuf;
    case (lat_f3[1:0])
      2'b00:   merge_c[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
      2'b01:   merge_c[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
      default: merge_c = lat_wdata;
    endcase
  end

  // Memory-side outputs decode from the state register and latched data only,
  // so reset removes a pending write immediately.
  assign bus.mem_wrt      = (state == WR);
  assign bus.mem_wrt_data = (state == WR) ? merge_c : 32'd0;
  assign bus.mem_addr     = lat_addr[LAW-1:2];

  // Request latch, read buffer and core-side response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_f3    <= 3'd0;
      lat_wdata <= 32'd0;
      rbuf      <= 32'd0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= 32'd0;
    end else begin
      bus.busy <= (next_state != IDLE);
      bus.done <= (next_state == RESP);
      // Only the IDLE->RESP shortcut carries an error.
      bus.err  <= accept_c && acc_err_c;
      if (accept_c) begin
        lat_addr  <= bus.addr[LAW-1:0];
        lat_we    <= bus.we;
        lat_f3    <= bus.funct3;
        lat_wdata <= bus.wdata;
      end
      if (state == RD) begin
        rbuf <= bus.mem_rd_data;
        // Loads leave RD for RESP, so rdata updates on the edge entering RESP.
        if (!lat_we) begin
          bus.rdata <= load_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed test-plan transactions with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_lsu_ctrl;

  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  lsu_ctrl_if #(.AW(AW)) bus ();

  lsu_ctrl #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Data memory: asynchronous read, write on the clock edge.
  logic [31:0] tb_mem [256];
  bit          mem_ready = 1'b0;
  assign bus.mem_rd_data = tb_mem[bus.mem_addr];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= seed_word(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_wrt) begin
      tb_mem[bus.mem_addr] <= bus.mem_wrt_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted request expands into a list of per-cycle expectations.
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        wrt;
    logic        ld;
    logic [7:0]  widx;
    logic [31:0] wdat;
    logic [31:0] rval;
  } rec_t;

  rec_t        q [$];
  rec_t        cur = '0;
  logic [31:0] m_rdata = 32'd0;
  logic [7:0]  m_maddr = 8'd0;
  logic [31:0] model_mem [256];
  bit          model_ready = 1'b0;

  function automatic rec_t mk(input logic dn, input logic er, input logic wr, input logic ld,
                              input logic [7:0] wi, input logic [31:0] wd, input logic [31:0] rv);
    rec_t r;
    r.busy = 1'b1; r.done = dn; r.err = er; r.wrt = wr; r.ld = ld;
    r.widx = wi; r.wdat = wd; r.rval = rv;
    return r;
  endfunction

  task automatic model_accept(input logic w, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] wd);
    logic [7:0]  idx;
    logic [31:0] old, nw, bv, hv, v;
    int          sh8, sh16;
    bit          bad;
    idx  = a[9:2];
    old  = model_mem[idx];
    sh8  = 8 * int'(a[1:0]);
    sh16 = 16 * int'(a[1]);
    bad  = w ? (f > 3'd2) : (f == 3'd3 || f == 3'd6 || f == 3'd7);
    if ((f == 3'd1 || f == 3'd5) && a[0]) bad = 1'b1;
    if (f == 3'd2 && a[1:0] != 2'b00) bad = 1'b1;
    m_maddr = idx;
    if (bad) begin
      q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 32'd0));
    end else if (w) begin
      if (f == 3'd2)      nw = wd;
      else if (f == 3'd0) nw = (old & ~(32'hFF << sh8)) | ((wd & 32'hFF) << sh8);
      else                nw = (old & ~(32'hFFFF << sh16)) | ((wd & 32'hFFFF) << sh16);
      if (f != 3'd2) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 32'd0));
      q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, idx, nw, 32'd0));
      q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 32'd0));
    end else begin
      bv = (old >> sh8) & 32'hFF;
      hv = (old >> sh16) & 32'hFFFF;
      case (f)
        3'd0:    v = bv[7]  ? (bv | 32'hFFFFFF00) : bv;
        3'd1:    v = hv[15] ? (hv | 32'hFFFF0000) : hv;
        3'd4:    v = bv;
        3'd5:    v = hv;
        default: v = old;
      endcase
      q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 32'd0));
      q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 32'd0, v));
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (!model_ready) begin
        for (int i = 0; i < 256; i++) model_mem[i] = seed_word(i);
        model_ready = 1'b1;
      end
      q.delete();
      cur     = '0;
      m_rdata = 32'd0;
      m_maddr = 8'd0;
    end else begin
      if (cur.wrt) model_mem[cur.widx] = cur.wdat;
      if (q.size() > 0) begin
        cur = q.pop_front();
      end else if (cur.busy) begin
        cur = '0;
      end else if (bus.req) begin
        model_accept(bus.we, bus.funct3, bus.addr, bus.wdata);
        cur = q.pop_front();
      end
      if (cur.ld) m_rdata = cur.rval;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(cur.busy));
    chk("done", 32'(bus.done), 32'(cur.done));
    chk("err", 32'(bus.err), 32'(cur.err));
    chk("mem_wrt", 32'(bus.mem_wrt), 32'(cur.wrt));
    chk("mem_addr", 32'(bus.mem_addr), 32'(m_maddr));
    chk("rdata", bus.rdata, m_rdata);
    if (cur.wrt) chk("mem_wrt_data", bus.mem_wrt_data, cur.wdat);
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int g;
    g = 0;
    while (bus.busy !== 1'b0 && g < 20) begin
      @(negedge clk); #1;
      g++;
    end
    chk("idle_before_req", 32'(bus.busy), 32'd0);
  endtask

  task automatic txn(input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output int nwrt,
                     output logic e, output logic [7:0] waddr);
    wait_idle();
    bus.req = 1'b1; bus.we = w; bus.funct3 = f; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.req = 1'b0;
    lat = 0; nwrt = 0; waddr = 8'd0;
    forever begin
      @(negedge clk);
      if (bus.mem_wrt) begin
        nwrt++;
        waddr = bus.mem_addr;
      end
      if (bus.done) break;
      lat++;
      if (lat > 8) begin
        nvec++; nerr++;
        $display("FAIL done_timeout: no done within %0d cycles at %0t", lat, $time);
        break;
      end
    end
    e = bus.err;
    #1;
  endtask

  logic [31:0] err_addr [5] = '{32'h11, 32'h12, 32'h10, 32'h10, 32'h11};
  logic        err_we   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [2:0]  err_f3   [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2};
  logic [2:0]  legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int          lat, nw, lowcnt;
    logic        e;
    logic [7:0]  wa;
    int          dn [$];
    logic        bh [16];

    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wrt", 32'(bus.mem_wrt), 32'd0);
    chk("rst_mem_wrt_data", bus.mem_wrt_data, 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;

    // SW then the load variants on the same word.
    txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, lat, nw, e, wa);
    chk("sw_lat", 32'(lat), 32'd1);
    chk("sw_nwrt", 32'(nw), 32'd1);
    chk("sw_waddr", 32'(wa), 32'd4);
    chk("sw_err", 32'(e), 32'd0);
    chk("sw_mem4", tb_mem[4], 32'hDEADBEEF);

    txn(1'b0, 3'd0, 32'h13, 32'd0, lat, nw, e, wa);
    chk("lb_lat", 32'(lat), 32'd1);
    chk("lb_nwrt", 32'(nw), 32'd0);
    chk("lb_rdata", bus.rdata, 32'hFFFFFFDE);
    txn(1'b0, 3'd4, 32'h13, 32'd0, lat, nw, e, wa);
    chk("lbu_rdata", bus.rdata, 32'h000000DE);
    txn(1'b0, 3'd1, 32'h12, 32'd0, lat, nw, e, wa);
    chk("lh_rdata", bus.rdata, 32'hFFFFDEAD);
    txn(1'b0, 3'd5, 32'h10, 32'd0, lat, nw, e, wa);
    chk("lhu_rdata", bus.rdata, 32'h0000BEEF);
    txn(1'b0, 3'd2, 32'h10, 32'd0, lat, nw, e, wa);
    chk("lw_lat", 32'(lat), 32'd1);
    chk("lw_rdata", bus.rdata, 32'hDEADBEEF);

    // Sub-word stores go through read-modify-write.
    txn(1'b1, 3'd0, 32'h11, 32'h00000012, lat, nw, e, wa);
    chk("sb_lat", 32'(lat), 32'd2);
    chk("sb_nwrt", 32'(nw), 32'd1);
    chk("sb_mem4", tb_mem[4], 32'hDEAD12EF);
    txn(1'b1, 3'd1, 32'h12, 32'h00005555, lat, nw, e, wa);
    chk("sh_lat", 32'(lat), 32'd2);
    chk("sh_nwrt", 32'(nw), 32'd1);
    chk("sh_mem4", tb_mem[4], 32'h555512EF);
    chk("store_keeps_rdata", bus.rdata, 32'hDEADBEEF);

    // Misaligned and illegal accesses.
    for (int i = 0; i < 5; i++) begin
      txn(err_we[i], err_f3[i], err_addr[i], 32'hFFFFFFFF, lat, nw, e, wa);
      chk($sformatf("err%0d_flag", i), 32'(e), 32'd1);
      chk($sformatf("err%0d_lat", i), 32'(lat), 32'd0);
      chk($sformatf("err%0d_nwrt", i), 32'(nw), 32'd0);
      chk($sformatf("err%0d_rdata", i), bus.rdata, 32'hDEADBEEF);
    end
    chk("err_mem4", tb_mem[4], 32'h555512EF);

    // High address bits alias onto the same word.
    txn(1'b0, 3'd2, 32'hFFFFFC10, 32'd0, lat, nw, e, wa);
    chk("alias_rdata", bus.rdata, 32'h555512EF);

    // Reset during the WR cycle of an SB must not commit the write.
    wait_idle();
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'd0; bus.addr = 32'h11; bus.wdata = 32'h77;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstwr_in_wr", 32'(bus.mem_wrt), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rstwr_mem_wrt", 32'(bus.mem_wrt), 32'd0);
    chk("rstwr_wrt_data", bus.mem_wrt_data, 32'd0);
    chk("rstwr_busy", 32'(bus.busy), 32'd0);
    chk("rstwr_done", 32'(bus.done), 32'd0);
    chk("rstwr_rdata", bus.rdata, 32'd0);
    chk("rstwr_mem_addr", 32'(bus.mem_addr), 32'd0);
    @(posedge clk);
    @(negedge clk); #1;
    chk("rstwr_mem4", tb_mem[4], 32'h555512EF);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwr_idle", 32'(bus.busy), 32'd0);
    #1;

    // req held high: back-to-back LW with one idle cycle between transactions.
    wait_idle();
    bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'd2; bus.addr = 32'h10; bus.wdata = 32'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bh[i] = bus.busy;
      if (bus.done) dn.push_back(i);
    end
    #1 bus.req = 1'b0;
    chk("b2b_count", 32'(dn.size()), 32'd5);
    for (int k = 1; k < dn.size(); k++) begin
      lowcnt = 0;
      for (int j = dn[k-1] + 1; j < dn[k]; j++) if (!bh[j]) lowcnt++;
      chk($sformatf("b2b_period%0d", k), 32'(dn[k] - dn[k-1]), 32'd3);
      chk($sformatf("b2b_idle%0d", k), 32'(lowcnt), 32'd1);
    end
    chk("b2b_rdata", bus.rdata, 32'h555512EF);

    // Randomized traffic over a small window of words, with rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
      end
      bus.req    = ($urandom_range(0, 3) != 0);
      bus.we     = 1'($urandom_range(0, 1));
      bus.funct3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)]
                                               : 3'($urandom_range(0, 7));
      bus.addr   = {22'($urandom), 8'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 1) == 0) bus.addr[1:0] = 2'b00;
      bus.wdata  = $urandom;
    end
    bus.req = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    for (int i = 0; i < 256; i++) chk($sformatf("mem_word[%0d]", i), tb_mem[i], model_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
